flow_led_multi: RTL

//  Parametrised running-light controller driving LED_NUM board LEDs from sys_clk.
//  A prescaler produces one step every CNT_MAX clocks. Each step advances the LED

---
 rtl/flow_led_multi.sv | 133 +++++++++++++
 1 files changed

// File: rtl/flow_led_multi.sv
// flow_led_multi: running-light controller for LED_NUM board LEDs.
// A prescaler produces one step every CNT_MAX clocks. On each step the pattern
// either reloads (mode changed) or advances in the selected mode: rotate left,
// rotate right, ping-pong or blink-all.
// Optional feature macro: FLOW_LED_PWM_EN adds a duty input and PWM brightness gating.
module flow_led_multi #(
   parameter int LED_NUM = 4,
   parameter int CNT_MAX = 10_000_000,
   parameter int CNT_W   = 24,
   parameter int PWM_W   = 4
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [1:0]         mode,
   input  logic               pause,
`ifdef FLOW_LED_PWM_EN
   input  logic [PWM_W-1:0]   duty,
`endif
   output logic [LED_NUM-1:0] led,
   output logic               step_pulse
);

   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CNT_MAX - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [LED_NUM-1:0] PAT_LSB  = LED_NUM'(1);
   localparam logic [LED_NUM-1:0] PAT_MSB  = PAT_LSB << (LED_NUM - 1);
   localparam logic [LED_NUM-1:0] PAT_ONES = '1;

   localparam logic [1:0] MODE_ROTL  = 2'b00;
   localparam logic [1:0] MODE_ROTR  = 2'b01;
   localparam logic [1:0] MODE_PING  = 2'b10;
   localparam logic [1:0] MODE_BLINK = 2'b11;

   logic [CNT_W-1:0]   cnt;
   logic [LED_NUM-1:0] pat;
   logic [LED_NUM-1:0] pat_next;
   logic [1:0]         mode_q;
   logic               dir;       // 0 = up (shifting left), 1 = down
   logic               dir_next;
   logic               step;
   logic               one_hot;

   // Starting pattern for each mode; also used to recover from a corrupted pattern.
   function automatic logic [LED_NUM-1:0] init_pat(input logic [1:0] m);
      case (m)
         MODE_ROTR:  init_pat = PAT_MSB;
         MODE_BLINK: init_pat = PAT_ONES;
         default:    init_pat = PAT_LSB;
      endcase
   endfunction

   assign step    = !pause && (cnt == CNT_LAST);
   assign one_hot = (pat != '0) && ((pat & (pat - PAT_LSB)) == '0);

   // Prescaler: holds while paused, wraps on the step edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt <= '0;
      end else if (!pause) begin
         if (cnt == CNT_LAST) cnt <= '0;
         else                 cnt <= cnt + CNT_ONE;
      end
   end

   // Next pattern/direction, applied only on a step edge.
   always_comb begin
      pat_next = pat;
      dir_next = dir;
      if (mode != mode_q) begin
         pat_next = init_pat(mode);
         dir_next = 1'b0;
      end else if (mode_q != MODE_BLINK && !one_hot) begin
         pat_next = init_pat(mode_q);
         dir_next = 1'b0;
      end else begin
         case (mode_q)
            MODE_ROTL: pat_next = {pat[LED_NUM-2:0], pat[LED_NUM-1]};
            MODE_ROTR: pat_next = {pat[0], pat[LED_NUM-1:1]};
            MODE_PING: begin
               // Turn around as soon as an end LED lights, so ends are never repeated.
               if (!dir) begin
                  pat_next = pat << 1;
                  dir_next = pat_next[LED_NUM-1];
               end else begin
                  pat_next = pat >> 1;
                  dir_next = !pat_next[0];
               end
            end
            default:   pat_next = ~pat;
         endcase
      end
   end

   // Pattern, direction and sampled mode update only on step edges.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pat    <= PAT_LSB;
         dir    <= 1'b0;
         mode_q <= MODE_ROTL;
      end else if (step) begin
         pat    <= pat_next;
         dir    <= dir_next;
         mode_q <= mode;
      end
   end

   // Strobe is registered so it coincides with the first cycle of the new pattern.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) step_pulse <= 1'b0;
      else            step_pulse <= step;
   end

`ifdef FLOW_LED_PWM_EN
   logic [PWM_W-1:0] pwm_cnt;
   logic             gate;

   // Free-running brightness counter and registered gate; unaffected by pause.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pwm_cnt <= '0;
         gate    <= 1'b0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_W'(1);
         gate    <= (pwm_cnt < duty);
      end
   end

   assign led = pat & {LED_NUM{gate}};
`else
   assign led = pat;
`endif

endmodule
